// File: rtl/bme280_pkg.sv
// Shared constants and types for the BME280 init/poll sequencer.
package bme280_pkg;

  localparam logic [7:0] REG_CHIP_ID    = 8'hD0;
  localparam logic [7:0] REG_CTRL_HUM   = 8'hF2;
  localparam logic [7:0] REG_CTRL_MEAS  = 8'hF4;
  localparam logic [7:0] REG_CONFIG     = 8'hF5;
  localparam logic [7:0] REG_BURST      = 8'hF7;

  localparam logic [7:0] CHIP_ID_BME280 = 8'h60;

  localparam int unsigned STEP_COUNT      = 12;
  localparam logic [3:0]  STEP_ID         = 4'd0;
  localparam logic [3:0]  STEP_FIRST_READ = 4'd4;
  localparam logic [3:0]  STEP_LAST       = 4'(STEP_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_NEXT,
    ST_POLL,
    ST_PUBLISH,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic       rw;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } step_t;

endpackage

// File: rtl/bme280_step_rom.sv
// Step table: maps step index to the I2C transaction it performs.
module bme280_step_rom
  import bme280_pkg::*;
#(
  parameter logic [7:0] CTRL_HUM  = 8'h01,
  parameter logic [7:0] CONFIG    = 8'hA0,
  parameter logic [7:0] CTRL_MEAS = 8'h27
) (
  input  logic [3:0] idx,
  output step_t      step
);

  // Chip-ID read, three config writes (ctrl_hum must precede ctrl_meas), then burst reads.
  always_comb begin
    step = '0;
    case (idx)
      4'd0: step = '{rw: 1'b1, reg_addr: REG_CHIP_ID,   wdata: 8'h00};
      4'd1: step = '{rw: 1'b0, reg_addr: REG_CTRL_HUM,  wdata: CTRL_HUM};
      4'd2: step = '{rw: 1'b0, reg_addr: REG_CONFIG,    wdata: CONFIG};
      4'd3: step = '{rw: 1'b0, reg_addr: REG_CTRL_MEAS, wdata: CTRL_MEAS};
      default: begin
        if (idx >= STEP_FIRST_READ && idx <= STEP_LAST)
          step = '{rw: 1'b1, reg_addr: REG_BURST + 8'(idx - STEP_FIRST_READ), wdata: 8'h00};
      end
    endcase
  end

endmodule

// File: rtl/bme280_sequencer.sv
// BME280 controller: chip-ID check, configuration writes, periodic burst reads
// assembled into raw pressure/temperature/humidity samples.
module bme280_sequencer
  import bme280_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h76,
  parameter logic [7:0]  CHIP_ID     = CHIP_ID_BME280,
  parameter logic [7:0]  CTRL_HUM    = 8'h01,
  parameter logic [7:0]  CONFIG      = 8'hA0,
  parameter logic [7:0]  CTRL_MEAS   = 8'h27,
  parameter int unsigned POLL_CYCLES = 100000,
  parameter int unsigned TIMEOUT     = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        i2c_en,
  output logic [6:0]  i2c_slave_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wdata,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_busy,
  output logic [19:0] raw_press,
  output logic [19:0] raw_temp,
  output logic [15:0] raw_hum,
  output logic        sample_valid,
  output logic        busy,
  output logic        error
);

  localparam int unsigned PW = $clog2(POLL_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t         state, state_d;
  logic [3:0]     idx, idx_d;
  logic           start_q;
  logic           start_rise;
  logic [TW-1:0]  tmo;
  logic [PW-1:0]  poll_cnt;
  logic [7:0]     id_q;
  logic [7:0]     rx_bytes [8];
  step_t          step;

  assign i2c_slave_addr = SLAVE_ADDR;
  assign start_rise     = start & ~start_q;
  assign busy           = (state != ST_IDLE) && (state != ST_ERR);

  // The ROM looks at the next index so the transaction fields are registered
  // on the same edge that enters ISSUE, making them valid alongside i2c_en.
  bme280_step_rom #(
    .CTRL_HUM  (CTRL_HUM),
    .CONFIG    (CONFIG),
    .CTRL_MEAS (CTRL_MEAS)
  ) u_step_rom (
    .idx  (idx_d),
    .step (step)
  );

  // Next-state, next step index and the request pulse.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    i2c_en  = 1'b0;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (start_rise) begin
          state_d = ST_ISSUE;
          idx_d   = STEP_ID;
        end
      end
      ST_ISSUE: begin
        if (!i2c_busy) begin
          i2c_en  = 1'b1;
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (i2c_busy)                 state_d = ST_WAIT_LO;
        else if (tmo == TW'(TIMEOUT)) state_d = ST_ERR;
      end
      ST_WAIT_LO: begin
        if (!i2c_busy)                state_d = ST_NEXT;
        else if (tmo == TW'(TIMEOUT)) state_d = ST_ERR;
      end
      ST_NEXT: begin
        if (idx == STEP_ID && id_q != CHIP_ID) begin
          state_d = ST_ERR;
        end else if (idx == STEP_LAST) begin
          state_d = ST_PUBLISH;
        end else begin
          idx_d   = idx + 4'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_PUBLISH: begin
        idx_d   = STEP_FIRST_READ;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        if (poll_cnt == '0) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, captured bytes and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      start_q      <= 1'b0;
      tmo          <= '0;
      poll_cnt     <= '0;
      id_q         <= '0;
      rx_bytes     <= '{default: '0};
      i2c_rw       <= 1'b0;
      i2c_reg_addr <= '0;
      i2c_wdata    <= '0;
      raw_press    <= '0;
      raw_temp     <= '0;
      raw_hum      <= '0;
      sample_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      start_q <= start;

      if (state_d != state)
        tmo <= '0;
      else if (state == ST_WAIT_HI || state == ST_WAIT_LO)
        tmo <= tmo + 1'b1;

      if (state == ST_PUBLISH)
        poll_cnt <= PW'(POLL_CYCLES - 1);
      else if (state == ST_POLL && poll_cnt != '0)
        poll_cnt <= poll_cnt - 1'b1;

      if (state == ST_WAIT_LO && !i2c_busy) begin
        if (idx == STEP_ID)
          id_q <= i2c_rdata;
        else if (idx >= STEP_FIRST_READ)
          rx_bytes[3'(idx - STEP_FIRST_READ)] <= i2c_rdata;
      end

      if (state_d == ST_ISSUE)
        {i2c_rw, i2c_reg_addr, i2c_wdata} <= step;

      sample_valid <= (state == ST_PUBLISH);
      if (state == ST_PUBLISH) begin
        raw_press <= {rx_bytes[0], rx_bytes[1], rx_bytes[2][7:4]};
        raw_temp  <= {rx_bytes[3], rx_bytes[4], rx_bytes[5][7:4]};
        raw_hum   <= {rx_bytes[6], rx_bytes[7]};
      end

      error <= (state_d == ST_ERR);
    end
  end

endmodule

// File: tb/tb_bme280_sequencer.sv
// Directed bench for bme280_sequencer with a behavioural single-byte I2C master/sensor.
module tb_bme280_sequencer;

  localparam int unsigned POLL_CYCLES = 50;
  localparam int unsigned TIMEOUT     = 20;

  logic        clk, rst, start;
  logic        i2c_en;
  logic [6:0]  i2c_slave_addr;
  logic        i2c_rw;
  logic [7:0]  i2c_reg_addr, i2c_wdata, i2c_rdata;
  logic        i2c_busy;
  logic [19:0] raw_press, raw_temp;
  logic [15:0] raw_hum;
  logic        sample_valid, busy, error;

  int checks;
  int failures;
  int cyc;

  logic [7:0] slave_id;
  logic [7:0] burst [8];
  logic       stuck;

  logic [7:0] log_reg [128];
  logic       log_rw  [128];
  logic [7:0] log_wd  [128];
  int         log_cyc [128];
  int         n_txn;
  int         en_busy_viol;
  int         last_sv_cyc;

  bme280_sequencer #(
    .POLL_CYCLES (POLL_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .i2c_en         (i2c_en),
    .i2c_slave_addr (i2c_slave_addr),
    .i2c_rw         (i2c_rw),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_wdata      (i2c_wdata),
    .i2c_rdata      (i2c_rdata),
    .i2c_busy       (i2c_busy),
    .raw_press      (raw_press),
    .raw_temp       (raw_temp),
    .raw_hum        (raw_hum),
    .sample_valid   (sample_valid),
    .busy           (busy),
    .error          (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Master + sensor model: busy rises 2 cycles after en, falls 3 cycles later with data.
  initial begin
    int phase;
    int mcnt;
    logic [7:0] cur_reg;
    i2c_busy = 1'b0;
    i2c_rdata = 8'h00;
    n_txn = 0;
    en_busy_viol = 0;
    phase = 0;
    mcnt = 0;
    cur_reg = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        i2c_busy = 1'b0;
        phase = 0;
      end else begin
        if (i2c_en === 1'b1 && i2c_busy) en_busy_viol++;
        case (phase)
          0: begin
            if (i2c_en === 1'b1) begin
              if (n_txn < 128) begin
                log_reg[n_txn] = i2c_reg_addr;
                log_rw[n_txn]  = i2c_rw;
                log_wd[n_txn]  = i2c_wdata;
                log_cyc[n_txn] = cyc;
              end
              n_txn++;
              cur_reg = i2c_reg_addr;
              if (!stuck) begin
                phase = 1;
                mcnt = 0;
              end
            end
          end
          1: begin
            mcnt++;
            if (mcnt == 2) begin
              i2c_busy = 1'b1;
              phase = 2;
              mcnt = 0;
            end
          end
          default: begin
            mcnt++;
            if (mcnt == 3) begin
              if (cur_reg == 8'hD0)      i2c_rdata = slave_id;
              else if (cur_reg >= 8'hF7) i2c_rdata = burst[3'(cur_reg - 8'hF7)];
              else                       i2c_rdata = 8'h00;
              i2c_busy = 1'b0;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_sv(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_err(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (error === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i2c_en, i2c_rw, i2c_reg_addr, i2c_wdata, sample_valid, busy, error} !== 20'h0) begin
      failures++;
      $display("FAIL reset_ctrl got en=%b rw=%b reg=%h wd=%h sv=%b busy=%b err=%b exp all 0",
               i2c_en, i2c_rw, i2c_reg_addr, i2c_wdata, sample_valid, busy, error);
    end
    checks++;
    if ({raw_press, raw_temp, raw_hum} !== 56'h0) begin
      failures++;
      $display("FAIL reset_raw got %h %h %h exp 0", raw_press, raw_temp, raw_hum);
    end
    checks++;
    if (i2c_slave_addr !== 7'h76) begin
      failures++;
      $display("FAIL slave_addr got %h exp 76", i2c_slave_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init_burst();
    logic [7:0] exp_reg [12];
    logic [7:0] exp_wd  [12];
    logic       exp_rw  [12];
    int base;
    bit seen;
    exp_reg = '{8'hD0, 8'hF2, 8'hF5, 8'hF4, 8'hF7, 8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE};
    exp_wd  = '{8'h00, 8'h01, 8'hA0, 8'h27, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_rw  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    slave_id = 8'h60;
    burst = '{8'h50, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h66, 8'h77};
    base = n_txn;
    pulse_start();
    wait_sv(1000, seen);
    last_sv_cyc = cyc;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL init_sample_valid got none exp pulse within 1000 cycles");
    end
    checks++;
    if (n_txn - base != 12) begin
      failures++;
      $display("FAIL init_txn_count got %0d exp 12", n_txn - base);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (log_rw[base+i] !== exp_rw[i] || log_reg[base+i] !== exp_reg[i] ||
          (!exp_rw[i] && log_wd[base+i] !== exp_wd[i])) begin
        failures++;
        $display("FAIL init_txn%0d got rw=%b reg=%h wd=%h exp rw=%b reg=%h wd=%h", i,
                 log_rw[base+i], log_reg[base+i], log_wd[base+i], exp_rw[i], exp_reg[i], exp_wd[i]);
      end
    end
    checks++;
    if (raw_press !== 20'h50000 || raw_temp !== 20'h80000 || raw_hum !== 16'h6677) begin
      failures++;
      $display("FAIL init_raw got p=%h t=%h h=%h exp p=50000 t=80000 h=6677",
               raw_press, raw_temp, raw_hum);
    end
    @(negedge clk);
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL sv_width got %b exp 0 one cycle after pulse", sample_valid);
    end
  endtask

  task automatic test_poll();
    int base;
    int sv0;
    bit seen;
    sv0 = last_sv_cyc;
    base = n_txn;
    burst = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    pulse_start();
    wait_sv(1000, seen);
    last_sv_cyc = cyc;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL poll_sample_valid got none exp pulse within 1000 cycles");
    end
    checks++;
    if (log_cyc[base] - sv0 != int'(POLL_CYCLES)) begin
      failures++;
      $display("FAIL poll_interval got %0d exp %0d", log_cyc[base] - sv0, POLL_CYCLES);
    end
    checks++;
    if (n_txn - base != 8) begin
      failures++;
      $display("FAIL poll_txn_count got %0d exp 8", n_txn - base);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_rw[base+i] !== 1'b1 || log_reg[base+i] !== 8'hF7 + 8'(i)) begin
        failures++;
        $display("FAIL poll_txn%0d got rw=%b reg=%h exp rw=1 reg=%h", i,
                 log_rw[base+i], log_reg[base+i], 8'hF7 + 8'(i));
      end
    end
    checks++;
    if (raw_press !== 20'h12345 || raw_temp !== 20'h789AB || raw_hum !== 16'hDEF0) begin
      failures++;
      $display("FAIL poll_raw got p=%h t=%h h=%h exp p=12345 t=789ab h=def0",
               raw_press, raw_temp, raw_hum);
    end
  endtask

  task automatic test_rst_midburst();
    int base;
    bit seen;
    base = n_txn;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (n_txn > base && log_reg[n_txn-1] == 8'hFA) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_find_fa got none exp read of FA within 1000 cycles");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({i2c_en, i2c_rw, i2c_reg_addr, i2c_wdata, sample_valid, busy, error} !== 20'h0) begin
      failures++;
      $display("FAIL rst_mid_ctrl got en=%b rw=%b reg=%h wd=%h sv=%b busy=%b err=%b exp all 0",
               i2c_en, i2c_rw, i2c_reg_addr, i2c_wdata, sample_valid, busy, error);
    end
    checks++;
    if ({raw_press, raw_temp, raw_hum} !== 56'h0) begin
      failures++;
      $display("FAIL rst_mid_raw got %h %h %h exp 0", raw_press, raw_temp, raw_hum);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bad_id();
    int base;
    bit seen;
    slave_id = 8'h58;
    base = n_txn;
    pulse_start();
    wait_err(500, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL badid_error got none exp error within 500 cycles");
    end
    repeat (10) @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL badid_hold got err=%b busy=%b exp err=1 busy=0", error, busy);
    end
    checks++;
    if (n_txn - base != 1 || log_reg[base] !== 8'hD0 || log_rw[base] !== 1'b1) begin
      failures++;
      $display("FAIL badid_txns got n=%0d reg=%h rw=%b exp n=1 reg=d0 rw=1",
               n_txn - base, log_reg[base], log_rw[base]);
    end
    slave_id = 8'h60;
    base = n_txn;
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL retry_clear got err=%b busy=%b exp err=0 busy=1", error, busy);
    end
    wait_sv(1000, seen);
    checks++;
    if (!seen || n_txn - base != 12 || log_reg[base+1] !== 8'hF2) begin
      failures++;
      $display("FAIL retry_run got sv=%b n=%0d reg1=%h exp sv=1 n=12 reg1=f2",
               seen, n_txn - base, log_reg[base+1]);
    end
  endtask

  task automatic test_timeout();
    int base;
    bit seen;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stuck = 1'b1;
    base = n_txn;
    pulse_start();
    wait_err(200, seen);
    checks++;
    if (!seen || cyc - log_cyc[base] != int'(TIMEOUT) + 2) begin
      failures++;
      $display("FAIL timeout_latency got seen=%b cycles=%0d exp seen=1 cycles=%0d",
               seen, cyc - log_cyc[base], TIMEOUT + 2);
    end
    checks++;
    if (busy !== 1'b0 || i2c_en !== 1'b0 || n_txn - base != 1) begin
      failures++;
      $display("FAIL timeout_state got busy=%b en=%b n=%0d exp busy=0 en=0 n=1",
               busy, i2c_en, n_txn - base);
    end
    stuck = 1'b0;
  endtask

  task automatic test_no_en_while_busy();
    checks++;
    if (en_busy_viol != 0) begin
      failures++;
      $display("FAIL en_while_busy got %0d exp 0", en_busy_viol);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    stuck = 1'b0;
    slave_id = 8'h60;
    burst = '{default: 8'h00};
    last_sv_cyc = 0;
    test_reset();
    test_init_burst();
    test_poll();
    test_rst_midburst();
    test_bad_id();
    test_timeout();
    test_no_en_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
